// File: rtl/shift_pkg.sv
// Shared encodings and the decoded-operation control word for the shifter-operand pipe.
package shift_pkg;

    localparam int unsigned IMM_AMT_W = 5;
    localparam int unsigned RS_AMT_W  = 8;
    localparam int unsigned DEC_AMT_W = 9;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        FORM_IMM = 2'b00,
        FORM_REG = 2'b01,
        FORM_ROT = 2'b10,
        FORM_RSV = 2'b11
    } form_t;

    // ovr forces an all-ovr_bit result; cfix_en replaces the network carry with cfix.
    typedef struct packed {
        shift_t sh_type;
        logic   fill;
        logic   ovr;
        logic   ovr_bit;
        logic   cfix_en;
        logic   cfix;
    } dec_ctl_t;

endpackage

// File: rtl/shift_operand_pipe_if.sv
// Request/response bundle between the operand source, the shifter pipe and the ALU.
interface shift_operand_pipe_if
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           form;
    logic [1:0]           shift_type;
    logic [IMM_AMT_W-1:0] imm_amt;
    logic [RS_AMT_W-1:0]  rs_amt;
    logic [WIDTH-1:0]     operand;
    logic                 carry_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic                 carry_out;

    modport master (
        output in_valid, form, shift_type, imm_amt, rs_amt, operand, carry_in, out_ready,
        input  in_ready, out_valid, result, carry_out
    );

    modport slave (
        input  in_valid, form, shift_type, imm_amt, rs_amt, operand, carry_in, out_ready,
        output in_ready, out_valid, result, carry_out
    );
endinterface

// File: rtl/shift_level.sv
// One log-step of the barrel network on {catch_hi, operand, catch_lo}; the catch bits
// collect the last bit shifted out so carry-out falls out of the same mux tree.
module shift_level
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHIFT = 1
) (
    input  shift_t           sh_type,
    input  logic             en,
    input  logic             fill,
    input  logic [WIDTH+1:0] d,
    output logic [WIDTH+1:0] q
);
    localparam int unsigned DW = WIDTH + 2;

    always_comb begin
        q = d;
        if (en) begin
            case (sh_type)
                SH_LSL:         q = d << SHIFT;
                SH_LSR, SH_ASR: q = {{SHIFT{fill}}, d[DW-1:SHIFT]};
                default:        q = {d[DW-1], d[SHIFT:1], d[WIDTH:SHIFT+1], d[0]};
            endcase
        end
    end
endmodule

// File: rtl/shift_operand_pipe.sv
// Pipelined ARM shifter-operand unit: decode to a normalised shift, log-step network
// split across PIPE_STAGES globally stalled stages, boundary fix-up in the last stage.
module shift_operand_pipe
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_operand_pipe_if.slave bus
);
    localparam int unsigned LOG2W = $clog2(WIDTH);
    localparam int unsigned BASE  = LOG2W / PIPE_STAGES;
    localparam int unsigned DW    = WIDTH + 2;

    logic                 advance;
    logic                 op_sign;
    logic                 dec_keep;
    logic                 dec_rrx;
    logic [DEC_AMT_W-1:0] dec_amt;
    dec_ctl_t             dec_ctl;
    logic [DW-1:0]        dec_d;

    logic [DW-1:0]        stg_d [PIPE_STAGES];
    dec_ctl_t             stg_c [PIPE_STAGES];
    logic [LOG2W-1:0]     stg_a [PIPE_STAGES];
    logic                 stg_v [PIPE_STAGES];

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;
    assign op_sign      = bus.operand[WIDTH-1];

    // Normalise all three operand forms to {type, amount, rrx, fixed carry}.
    always_comb begin
        dec_ctl         = '0;
        dec_ctl.sh_type = shift_t'(bus.shift_type);
        dec_amt         = DEC_AMT_W'(bus.imm_amt);
        dec_rrx         = 1'b0;
        dec_keep        = 1'b0;
        case (form_t'(bus.form))
            FORM_IMM: begin
                if (bus.imm_amt == '0) begin
                    case (dec_ctl.sh_type)
                        SH_LSL:         dec_keep = 1'b1;
                        SH_LSR, SH_ASR: dec_amt  = DEC_AMT_W'(WIDTH);
                        default: begin
                            dec_ctl.sh_type = SH_LSR;
                            dec_amt         = DEC_AMT_W'(1);
                            dec_rrx         = 1'b1;
                        end
                    endcase
                end
            end
            FORM_REG: begin
                dec_amt  = DEC_AMT_W'(bus.rs_amt);
                dec_keep = (bus.rs_amt == '0);
            end
            FORM_ROT: begin
                dec_ctl.sh_type = SH_ROR;
                dec_amt         = DEC_AMT_W'({bus.imm_amt[3:0], 1'b0});
                dec_keep        = (bus.imm_amt[3:0] == '0);
            end
            default: dec_keep = 1'b1;
        endcase

        if (dec_keep) begin
            dec_ctl.sh_type = SH_ROR;
            dec_amt         = '0;
            dec_ctl.cfix_en = 1'b1;
            dec_ctl.cfix    = bus.carry_in;
        end else if (dec_ctl.sh_type != SH_ROR && dec_amt >= DEC_AMT_W'(WIDTH)) begin
            // Amounts at or past the width bypass the network entirely.
            dec_ctl.ovr     = 1'b1;
            dec_ctl.cfix_en = 1'b1;
            case (dec_ctl.sh_type)
                SH_LSL:  dec_ctl.cfix = (dec_amt == DEC_AMT_W'(WIDTH)) && bus.operand[0];
                SH_LSR:  dec_ctl.cfix = (dec_amt == DEC_AMT_W'(WIDTH)) && op_sign;
                default: begin
                    dec_ctl.ovr_bit = op_sign;
                    dec_ctl.cfix    = op_sign;
                end
            endcase
        end

        dec_ctl.fill = (dec_ctl.sh_type == SH_ASR) && op_sign;
        dec_d        = {dec_rrx ? bus.carry_in : dec_ctl.fill, bus.operand, 1'b0};
    end

    assign stg_d[0] = dec_d;
    assign stg_c[0] = dec_ctl;
    assign stg_a[0] = dec_amt[LOG2W-1:0];
    assign stg_v[0] = bus.in_valid;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int unsigned LO = s * BASE;
        localparam int unsigned NL = (s == PIPE_STAGES - 1) ? LOG2W - LO : BASE;

        logic [DW-1:0] lvl [NL+1];

        assign lvl[0] = stg_d[s];

        for (genvar l = 0; l < NL; l++) begin : g_lvl
            shift_level #(
                .WIDTH (WIDTH),
                .SHIFT (1 << (LO + l))
            ) u_level (
                .sh_type (stg_c[s].sh_type),
                .en      (stg_a[s][LO+l]),
                .fill    (stg_c[s].fill),
                .d       (lvl[l]),
                .q       (lvl[l+1])
            );
        end

        if (s < PIPE_STAGES - 1) begin : g_mid
            logic [DW-1:0]    d_q;
            dec_ctl_t         c_q;
            logic [LOG2W-1:0] a_q;
            logic             v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    d_q <= '0;
                    c_q <= '0;
                    a_q <= '0;
                end else if (advance) begin
                    v_q <= stg_v[s];
                    d_q <= lvl[NL];
                    c_q <= stg_c[s];
                    a_q <= stg_a[s];
                end
            end

            assign stg_d[s+1] = d_q;
            assign stg_c[s+1] = c_q;
            assign stg_a[s+1] = a_q;
            assign stg_v[s+1] = v_q;
        end else begin : g_last
            logic [WIDTH-1:0] fin_res;
            logic             fin_c;

            // Carry is whichever catch bit the shift direction fills; overrides win.
            always_comb begin
                fin_res = lvl[NL][WIDTH:1];
                case (stg_c[s].sh_type)
                    SH_LSL:  fin_c = lvl[NL][DW-1];
                    SH_ROR:  fin_c = lvl[NL][WIDTH];
                    default: fin_c = lvl[NL][0];
                endcase
                if (stg_c[s].ovr) begin
                    fin_res = {WIDTH{stg_c[s].ovr_bit}};
                end
                if (stg_c[s].cfix_en) begin
                    fin_c = stg_c[s].cfix;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bus.out_valid <= 1'b0;
                    bus.result    <= '0;
                    bus.carry_out <= 1'b0;
                end else if (advance) begin
                    bus.out_valid <= stg_v[s];
                    if (stg_v[s]) begin
                        bus.result    <= fin_res;
                        bus.carry_out <= fin_c;
                    end
                end
            end
        end
    end
endmodule
